// File: rtl/mem_stage_if.sv
// Interface bundling the MEM stage handshake, payload, data-port response and
// the hazard/forward buses returned to ID. The slave modport is the MEM stage;
// the master modport is its environment (EX, WB, data SRAM, ID).
interface mem_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 123,
    parameter int MS_TO_WS_BUS_WD = 86,
    parameter int STALL_BUS_WD    = 10,
    parameter int FORWARD_BUS_WD  = 33
) ();
    logic                       flush;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic [STALL_BUS_WD-1:0]    stall_ms_bus;
    logic [FORWARD_BUS_WD-1:0]  forward_ms_bus;
    logic                       ms_exc_eret;

    modport master (
        output flush, ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus, ms_exc_eret
    );

    modport slave (
        input  flush, ws_allowin, es_to_ms_valid, es_to_ms_bus,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus, ms_exc_eret
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX->MEM payload, waits for the data-port
// response of an issued load, extracts/merges load data (incl. LWL/LWR) and
// hands the result to WB. Also publishes hazard/forward info to ID and drops
// a load response that belongs to an instruction killed by a WB flush.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 123,
    parameter int MS_TO_WS_BUS_WD = 86,
    parameter int STALL_BUS_WD    = 10,
    parameter int FORWARD_BUS_WD  = 33
) (
    input  logic          clk,
    input  logic          reset,
    mem_stage_if.slave    bus
);

    // Load extraction/merge; a is the byte offset within the word.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  load_op,
        input logic [1:0]  a,
        input logic [31:0] d,
        input logic [31:0] rt
    );
        logic [31:0]        byte_sh;
        logic [31:0]        half_sh;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [31:0]        res;
        byte_sh = d >> {a, 3'b000};
        half_sh = d >> {a[1], 4'b0000};
        byte_s  = byte_sh[7:0];
        half_s  = half_sh[15:0];
        case (load_op)
            3'd1: res = 32'(byte_s);
            3'd2: res = {24'd0, byte_sh[7:0]};
            3'd3: res = 32'(half_s);
            3'd4: res = {16'd0, half_sh[15:0]};
            3'd5: begin
                case (a)
                    2'd0:    res = {d[7:0],  rt[23:0]};
                    2'd1:    res = {d[15:0], rt[15:0]};
                    2'd2:    res = {d[23:0], rt[7:0]};
                    default: res = d;
                endcase
            end
            3'd6: begin
                case (a)
                    2'd0:    res = d;
                    2'd1:    res = {rt[31:24], d[31:8]};
                    2'd2:    res = {rt[31:16], d[31:16]};
                    default: res = {rt[31:8],  d[31:24]};
                endcase
            end
            default: res = d;
        endcase
        return res;
    endfunction

    logic                       vld_p0;
    logic [ES_TO_MS_BUS_WD-1:0] bus_p0;
    logic                       rbuf_vld_p0;
    logic [31:0]                rbuf_p0;
    logic                       cancel_pend;

    logic [31:0] rt_value;
    logic [2:0]  load_op;
    logic        res_from_mem;
    logic        req_sent;
    logic        exc_sys;
    logic        eret;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;

    logic        need_data;
    logic        resp_live;
    logic        ready_go;
    logic        allowin;
    logic        to_ws_valid;
    logic        leave;
    logic        rbuf_load;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign rt_value     = bus_p0[122:91];
    assign load_op      = bus_p0[90:88];
    assign res_from_mem = bus_p0[87];
    assign req_sent     = bus_p0[86];
    assign exc_sys      = bus_p0[84];
    assign eret         = bus_p0[83];
    assign gr_we        = bus_p0[72:69];
    assign dest         = bus_p0[68:64];
    assign alu_result   = bus_p0[63:32];

    assign need_data   = res_from_mem & req_sent;
    assign resp_live   = bus.data_sram_data_ok & ~cancel_pend;
    assign ready_go    = ~need_data | rbuf_vld_p0 | resp_live;
    assign allowin     = ~vld_p0 | (ready_go & bus.ws_allowin);
    assign to_ws_valid = vld_p0 & ready_go;
    assign leave       = to_ws_valid & bus.ws_allowin;
    assign rbuf_load   = resp_live & vld_p0 & need_data & ~bus.ws_allowin;

    assign load_data    = rbuf_vld_p0 ? rbuf_p0 : bus.data_sram_rdata;
    assign final_result = res_from_mem ? load_extract(load_op, alu_result[1:0], load_data, rt_value)
                                       : alu_result;

    assign bus.ms_allowin     = allowin;
    assign bus.ms_to_ws_valid = to_ws_valid;
    assign bus.ms_to_ws_bus   = {bus_p0[85:64], final_result, bus_p0[31:0]};
    assign bus.stall_ms_bus   = {vld_p0 & (|gr_we), gr_we & {4{vld_p0}}, dest};
    assign bus.forward_ms_bus = {vld_p0 & (~res_from_mem | ready_go), final_result};
    assign bus.ms_exc_eret    = vld_p0 & (exc_sys | eret);

    // Stage-valid, read-buffer-valid and stale-response tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0      <= 1'b0;
            rbuf_vld_p0 <= 1'b0;
            cancel_pend <= 1'b0;
        end else begin
            if (bus.flush) begin
                vld_p0 <= 1'b0;
            end else if (allowin) begin
                vld_p0 <= bus.es_to_ms_valid;
            end

            if (bus.flush || leave) begin
                rbuf_vld_p0 <= 1'b0;
            end else if (rbuf_load) begin
                rbuf_vld_p0 <= 1'b1;
            end

            // A flushed load still waiting for its response leaves one
            // response in flight; the next data_ok belongs to it.
            if (bus.flush && vld_p0 && need_data && !rbuf_vld_p0 && !bus.data_sram_data_ok) begin
                cancel_pend <= 1'b1;
            end else if (bus.data_sram_data_ok && cancel_pend) begin
                cancel_pend <= 1'b0;
            end
        end
    end

    // EX->MEM payload capture; data path needs no reset.
    always_ff @(posedge clk) begin
        if (bus.es_to_ms_valid && allowin) begin
            bus_p0 <= bus.es_to_ms_bus;
        end
    end

    // Hold the response when WB is not ready to take the instruction yet.
    always_ff @(posedge clk) begin
        if (rbuf_load) begin
            rbuf_p0 <= bus.data_sram_rdata;
        end
    end

endmodule
